// File: rtl/ps2_host_cmd.sv
// PS/2 host-to-device command sequencer: inhibit, request-to-send, 11-bit frame, line-ack, 0xFA/0xFE response with retry.
// Optional watchdog on the RTS/LACK/RESP phases is built when PS2_CMD_TIMEOUT_EN is defined.
module ps2_host_cmd #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       key_clk,
  input  logic       key_din,
  output logic       key_clk_oe,
  output logic       key_dout_oe,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       rx_strobe,
  input  logic [7:0] rx_byte,
  output logic       tx_active,
  output logic       done,
  output logic [1:0] status
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_RTS     = 3'd2;
  localparam logic [2:0] ST_LACK    = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] STAT_ACK    = 2'b00;
  localparam logic [1:0] STAT_NACK   = 2'b01;
  localparam logic [1:0] STAT_NOLACK = 2'b11;

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  logic [2:0]       state;
  logic [INH_W-1:0] inh_cnt;
  logic [3:0]       bit_cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic             dout_q;
  logic [7:0]       cmd_byte;
  logic [8:0]       shifter;

  logic clk_p0, clk_p1, clk_p2;
  logic din_p0, din_p1;
  logic fall;
  logic accept;
  logic resend;

  // Pad synchronizers; reset to the idle-high line level so release never fakes an edge.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      clk_p2 <= 1'b1;
      din_p0 <= 1'b1;
      din_p1 <= 1'b1;
    end else begin
      clk_p0 <= key_clk;
      clk_p1 <= clk_p0;
      clk_p2 <= clk_p1;
      din_p0 <= key_din;
      din_p1 <= din_p0;
    end
  end

  assign fall      = clk_p2 & ~clk_p1;
  assign cmd_ready = (state == ST_IDLE) & ~done & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  assign resend    = (state == ST_RESP) && rx_strobe && (rx_byte == 8'hFE) &&
                     (retry_cnt < RTY_W'(MAX_RETRY));

  assign tx_active   = (state == ST_INHIBIT) || (state == ST_RTS) || (state == ST_LACK);
  assign key_clk_oe  = (state == ST_INHIBIT);
  // Start bit is driven combinationally in the final inhibit cycle, then held by dout_q.
  assign key_dout_oe = dout_q | ((state == ST_INHIBIT) && (inh_cnt == '0));

`ifdef PS2_CMD_TIMEOUT_EN
  logic [WD_W-1:0] wdog;
`else
  logic [WD_W-1:0] wdog_unused;
  assign wdog_unused = '0;
`endif

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      inh_cnt   <= '0;
      bit_cnt   <= '0;
      retry_cnt <= '0;
      dout_q    <= 1'b0;
      done      <= 1'b0;
      status    <= STAT_ACK;
`ifdef PS2_CMD_TIMEOUT_EN
      wdog      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            retry_cnt <= '0;
            inh_cnt   <= INH_W'(INHIBIT_CYCLES - 1);
            bit_cnt   <= '0;
            state     <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (inh_cnt == '0) begin
            dout_q  <= 1'b1;
            bit_cnt <= '0;
            state   <= ST_RTS;
          end else begin
            inh_cnt <= inh_cnt - 1'b1;
          end
        end
        ST_RTS: begin
          // Edges 1-8 data, 9 parity, 10 stop (shifter[0]=1 releases the line).
          if (fall) begin
            dout_q <= ~shifter[0];
            if (bit_cnt == 4'd9) begin
              bit_cnt <= '0;
              state   <= ST_LACK;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_LACK: begin
          if (fall) begin
            if (!din_p1) begin
              state <= ST_RESP;
            end else begin
              state  <= ST_IDLE;
              done   <= 1'b1;
              status <= STAT_NOLACK;
            end
          end
        end
        ST_RESP: begin
          if (rx_strobe) begin
            if (rx_byte == 8'hFA) begin
              state  <= ST_IDLE;
              done   <= 1'b1;
              status <= STAT_ACK;
            end else if (resend) begin
              retry_cnt <= retry_cnt + 1'b1;
              inh_cnt   <= INH_W'(INHIBIT_CYCLES - 1);
              state     <= ST_INHIBIT;
            end else if (rx_byte == 8'hFE) begin
              state  <= ST_IDLE;
              done   <= 1'b1;
              status <= STAT_NACK;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
`ifdef PS2_CMD_TIMEOUT_EN
      if ((state == ST_RTS) || (state == ST_LACK) || (state == ST_RESP)) begin
        if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state  <= ST_IDLE;
          dout_q <= 1'b0;
          done   <= 1'b1;
          status <= 2'b10;
          wdog   <= '0;
        end else if (fall && ((state == ST_RTS) || (state == ST_LACK))) begin
          wdog <= '0;
        end else begin
          wdog <= wdog + 1'b1;
        end
      end else begin
        wdog <= '0;
      end
`endif
    end
  end

  // Frame data path: latched byte and shift register carry no reset.
  always_ff @(posedge clk25) begin
    if (accept) begin
      cmd_byte <= cmd_data;
      shifter  <= {1'b1, odd_par(cmd_data), cmd_data};
    end else if (resend) begin
      shifter <= {1'b1, odd_par(cmd_byte), cmd_byte};
    end else if ((state == ST_RTS) && fall) begin
      shifter <= {1'b1, shifter[8:1]};
    end
  end

endmodule

// File: tb/tb_ps2_host_cmd.sv
// Directed bench for ps2_host_cmd: PS/2 device model clocks the frame, returns line-ack and responses.
module tb_ps2_host_cmd;

  logic       clk25 = 1'b0;
  logic       rst = 1'b1;
  logic       key_clk, key_din;
  logic       key_clk_oe, key_dout_oe;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       rx_strobe = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_active, done;
  logic [1:0] status;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;

  assign key_clk = dev_clk & ~key_clk_oe;
  assign key_din = dev_dat & ~key_dout_oe;

  always #20 clk25 = ~clk25;

  ps2_host_cmd dut (
    .clk25(clk25), .rst(rst), .key_clk(key_clk), .key_din(key_din),
    .key_clk_oe(key_clk_oe), .key_dout_oe(key_dout_oe),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rx_strobe(rx_strobe), .rx_byte(rx_byte), .tx_active(tx_active),
    .done(done), .status(status)
  );

  localparam int HALF = 12;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int inh_starts = 0;
  int f11_cyc = 0;
  int exp_done = 0;
  logic [1:0] last_status = 2'b00;
  logic ready_at_done = 1'b0;
  logic ready_after = 1'b0;
  logic prev_done = 1'b0;
  logic prev_clk_oe = 1'b0;

  always @(posedge clk25) cyc <= cyc + 1;

  always @(negedge clk25) begin
    if (prev_done) ready_after <= cmd_ready;
    if (done) begin
      done_cnt      <= done_cnt + 1;
      last_status   <= status;
      ready_at_done <= cmd_ready;
      done_cyc      <= cyc;
    end
    prev_done <= done;
    if (key_clk_oe && !prev_clk_oe) inh_starts <= inh_starts + 1;
    prev_clk_oe <= key_clk_oe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    int n;
    @(negedge clk25);
    cmd_valid = 1'b1;
    cmd_data  = b;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk25);
      n++;
    end
    if (n >= 1000) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk25);
    cmd_valid = 1'b0;
    cmd_data  = ~b;
  endtask

  task automatic wait_inhibit(output int inh_len);
    int n;
    n = 0;
    while (!key_clk_oe && n < 20000) begin
      @(negedge clk25);
      n++;
    end
    inh_len = 0;
    while (key_clk_oe && inh_len < 20000) begin
      inh_len++;
      @(negedge clk25);
    end
  endtask

  task automatic dev_xfer(input logic ack, output logic [9:0] bits, output int inh_len);
    wait_inhibit(inh_len);
    chk("rts_start_bit", key_dout_oe, 1'b1);
    chk("rts_tx_active", tx_active, 1'b1);
    repeat (10) @(negedge clk25);
    for (int i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk25);
      bits[i] = ~key_dout_oe;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk25);
    end
    dev_dat = ack ? 1'b0 : 1'b1;
    repeat (4) @(negedge clk25);
    dev_clk = 1'b0;
    f11_cyc = cyc;
    repeat (HALF) @(negedge clk25);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (4) @(negedge clk25);
  endtask

  task automatic dev_resp(input logic [7:0] b);
    repeat (10) @(negedge clk25);
    rx_strobe = 1'b1;
    rx_byte   = b;
    @(negedge clk25);
    rx_strobe = 1'b0;
    rx_byte   = 8'h00;
  endtask

  task automatic wait_done(input string tag, input int exp_cnt, input logic [1:0] exp_st);
    int n;
    n = 0;
    while (done_cnt < exp_cnt && n < 70000) begin
      @(posedge clk25);
      n++;
    end
    repeat (2) @(posedge clk25);
    @(negedge clk25);
    chk({tag, "_done_cnt"}, done_cnt, exp_cnt);
    chk({tag, "_status"}, last_status, exp_st);
    chk({tag, "_ready_at_done"}, ready_at_done, 1'b0);
    chk({tag, "_ready_after"}, ready_after, 1'b1);
  endtask

  initial begin
    logic [9:0] bits;
    int inh;
    int s;

    repeat (3) @(negedge clk25);
    chk("rst_clk_oe", key_clk_oe, 1'b0);
    chk("rst_dout_oe", key_dout_oe, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_tx_active", tx_active, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_status", status, 2'b00);
    rst = 1'b0;
    @(negedge clk25);
    chk("idle_ready", cmd_ready, 1'b1);

    // 0xED: bits 1,0,1,1,0,1,1,1 parity 1 stop 1; an unrelated byte in RESP is ignored.
    send_cmd(8'hED);
    dev_xfer(1'b1, bits, inh);
    chk("ed_inhibit_len", inh, 2500);
    chk("ed_frame", bits, 10'h3ED);
    chk("ed_lack_dout", key_dout_oe, 1'b0);
    chk("ed_resp_tx_active", tx_active, 1'b0);
    dev_resp(8'hAA);
    repeat (5) @(negedge clk25);
    chk("ed_ignored_byte", done_cnt, exp_done);
    dev_resp(8'hFA);
    exp_done++;
    wait_done("ed", exp_done, 2'b00);

    // 0xFF: two resends then ACK.
    s = inh_starts;
    send_cmd(8'hFF);
    for (int k = 0; k < 3; k++) begin
      dev_xfer(1'b1, bits, inh);
      chk("ff_frame", bits, 10'h3FF);
      dev_resp((k < 2) ? 8'hFE : 8'hFA);
    end
    exp_done++;
    wait_done("ff", exp_done, 2'b00);
    chk("ff_inhibit_phases", inh_starts - s, 3);

    // 0x00: four 0xFE responses exhaust the retries.
    s = inh_starts;
    send_cmd(8'h00);
    for (int k = 0; k < 4; k++) begin
      dev_xfer(1'b1, bits, inh);
      chk("zero_parity", bits[8], 1'b1);
      chk("zero_frame", bits, 10'h300);
      dev_resp(8'hFE);
    end
    exp_done++;
    wait_done("zero", exp_done, 2'b01);
    chk("zero_tx_count", inh_starts - s, 4);

    // 0x55 with data left high on the 11th clock.
    send_cmd(8'h55);
    dev_xfer(1'b0, bits, inh);
    chk("nolack_frame", bits, 10'h355);
    exp_done++;
    wait_done("nolack", exp_done, 2'b11);
    chk("nolack_latency", ((done_cyc - f11_cyc) <= 6) ? 1 : 0, 1);
    dev_resp(8'hFA);
    repeat (5) @(negedge clk25);
    chk("idle_strobe_ignored", done_cnt, exp_done);

    // Reset during the 5th data bit of 0xAB (bit4 = 0, line pulled low).
    send_cmd(8'hAB);
    wait_inhibit(inh);
    repeat (10) @(negedge clk25);
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk25);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk25);
    end
    dev_clk = 1'b0;
    repeat (6) @(negedge clk25);
    chk("pre_rst_bit4", key_dout_oe, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_clk_oe", key_clk_oe, 1'b0);
    chk("rst_mid_dout_oe", key_dout_oe, 1'b0);
    repeat (3) @(negedge clk25);
    rst = 1'b0;
    dev_clk = 1'b1;
    repeat (3) @(negedge clk25);
    chk("rst_mid_ready", cmd_ready, 1'b1);
    chk("rst_mid_no_done", done_cnt, exp_done);

    send_cmd(8'hF4);
    dev_xfer(1'b1, bits, inh);
    chk("f4_frame", bits, 10'h2F4);
    dev_resp(8'hFA);
    exp_done++;
    wait_done("f4", exp_done, 2'b00);

`ifdef PS2_CMD_TIMEOUT_EN
    begin
      int t0;
      send_cmd(8'h12);
      wait_inhibit(inh);
      t0 = cyc;
      exp_done++;
      wait_done("tmo", exp_done, 2'b10);
      chk("tmo_window", ((done_cyc - t0 >= 49997) && (done_cyc - t0 <= 50003)) ? 1 : 0, 1);
      chk("tmo_clk_oe", key_clk_oe, 1'b0);
      chk("tmo_dout_oe", key_dout_oe, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_cmd.md
Name: ps2_host_cmd

Overview:
- Host-to-device command sequencer for the PS/2 keyboard port, on the same 25 MHz domain as the scancode receiver.
- Takes one command byte from the CPU-side logic (e.g. 0xED set-LEDs, 0xFF reset) and drives the PS/2 inhibit / request-to-send protocol.
- Shifts the byte out with odd parity, then checks the device line-ack bit.
- Arbitrates the bus against the receiver: waits for the device's 0xFA/0xFE response via the receiver's byte strobe and retries on 0xFE.

Parameters:
- INHIBIT_CYCLES, 2500, clk25 cycles the clock line is held low before request-to-send (100 us).
- MAX_RETRY, 3, resends allowed after 0xFE before reporting NACK.
- TIMEOUT_CYCLES, 50000, per-phase watchdog limit (2 ms); used only with PS2_CMD_TIMEOUT_EN.

Ports:
- clk25  in  1  25 MHz clock.
- rst  in  1  asynchronous, active-high reset.
- key_clk  in  1  PS/2 clock line as read back from the pad (raw).
- key_din  in  1  PS/2 data line as read back from the pad (raw).
- key_clk_oe  out  1  1 = pull PS/2 clock low (open drain); 0 = release.
- key_dout_oe  out  1  1 = pull PS/2 data low; 0 = release.
- cmd_valid  in  1  command request.
- cmd_data  in  8  command byte.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
- rx_strobe  in  1  one-cycle pulse from the receiver: a complete byte arrived.
- rx_byte  in  8  byte accompanying rx_strobe.
- tx_active  out  1  high from INHIBIT through LACK; the receiver clears its bit counter while this is high.
- done  out  1  one-cycle completion pulse.
- status  out  2  valid with done: 00 ACK, 01 NACK (retries exhausted), 10 timeout, 11 no line-ack.

Behaviour:
- Reset values: key_clk_oe=0, key_dout_oe=0, cmd_ready=0 during rst (1 from the first IDLE cycle), tx_active=0, done=0, status=00; state=IDLE, retry count=0, all counters 0.
- key_clk and key_din pass through a 2-flop synchronizer. A falling edge is prev_sync=1 & sync=0; edge detection has 3 cycles of latency.
- Frame on accept:
  - shift register = {1'b1 stop, odd parity of cmd_data, cmd_data}; the byte is latched so cmd_data may change afterwards.
  - Parity bit = ~^cmd_data.
- States:
  - IDLE: on accept, load shifter, retry count=0, load the inhibit counter, go INHIBIT.
  - INHIBIT: key_clk_oe=1 for exactly INHIBIT_CYCLES cycles. On the last cycle assert key_dout_oe=1 (start bit), go RTS.
  - RTS: key_clk_oe=0, key_dout_oe=1. On each detected falling edge, key_dout_oe <= ~shifter[0], shift right and count. Data bits 0..7 go out on edges 1-8, parity on edge 9, stop (released) on edge 10, then go LACK.
  - LACK: on the 11th falling edge sample synchronized key_din.
    - 0: line-ack good, go RESP.
    - 1: done, status=11, go IDLE.
  - RESP: tx_active=0, wait for rx_strobe.
    - 0xFA: done, status=00, go IDLE.
    - 0xFE with retry count < MAX_RETRY: increment the count, reload the original byte, go INHIBIT.
    - 0xFE with retries exhausted: done, status=01, go IDLE.
    - Any other byte is ignored; the device may still be flushing a scancode.
- rx_strobe outside RESP is ignored.
- cmd_valid while busy is not accepted; it must be held until cmd_ready.
- done is high exactly one cycle, in the cycle the state returns to IDLE; cmd_ready rises the following cycle.
- rst asserted mid-transfer: both oe outputs release immediately (async), state returns to IDLE, and no done pulse is issued.
- key_dout_oe is only ever 1 in INHIBIT's last cycle, RTS, and while shifting 0-bits; it is 0 from LACK onward.

Optional Feature:
- Macro PS2_CMD_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter restarts on entry to RTS, LACK and RESP, and on every falling edge in RTS.
  - If it reaches TIMEOUT_CYCLES: release both lines, done with status=10, go IDLE.
  - A timeout does not trigger a retry.
- Without the macro: no watchdog logic; RTS, LACK and RESP wait indefinitely. TIMEOUT_CYCLES is unused and status=10 never occurs.

Test Plan:
- Send 0xED with the device model returning line-ack and then 0xFA. Required: key_clk_oe low for 2500 cycles; data bits on the wire 1,0,1,1,0,1,1,1, parity 1, stop released; done with status=00.
- Send 0xFF with the device returning 0xFE, 0xFE, then 0xFA. Required: exactly 3 INHIBIT phases; done with status=00.
- Send 0x00 with the device returning 0xFE four times. Required: 4 transmissions with parity bit=1; done with status=01.
- Device leaves data high on the 11th clock. Required: done with status=11; the RESP phase is never entered.
- PS2_CMD_TIMEOUT_EN defined, device never clocks after RTS. Required: done with status=10 exactly 50000 cycles after RTS entry (±3 for synchronizer latency); both oe outputs 0.
- Assert rst during the 5th data bit. Required: key_clk_oe=key_dout_oe=0 within the same cycle, no done pulse, cmd_ready=1 after release; a subsequent 0xF4 command completes with status=00.
